grid_state_writer: RTL
======================

GRID_STATE_WRITER -- requirements
Module: grid_state_writer

Interface
REQ-001 SHALL have parameters, one per line: name, default, meaning:
- COOK_FRAMES, 180, frame ticks for a raw pot to become cooked.
- BURN_FRAMES, 240, frame ticks for a cooked pot to catch fire.
- POT0_X, 4 / POT0_Y, 0, grid cell of pot 0.
- POT1_X, 8 / POT1_Y, 0, grid cell of pot 1.
REQ-002 SHALL have ports, one per line: name, direction, width, meaning:
- pixel_clk_in, in, 1, the only clock.
- rst_n_in, in, 1, reset, asynchronous, active-low.
- frame_tick_in, in, 1, one-cycle pulse per video frame.
- cmd_valid_in, in, 1, command request.
- cmd_ready_out, out, 1, command can be accepted.
- cmd_swap_in, in, 1, 0 = write, 1 = swap (write and return the old value).
- cmd_x_in, in, 4, grid column, legal 0..12.
- cmd_y_in, in, 3, grid row, legal 0..7.
- cmd_obj_in, in, 4, object code to store.
- resp_valid_out, out, 1, one-cycle response strobe.
- resp_obj_out, out, 4, previous cell contents (swap only).
- resp_err_out, out, 1, command was out of range.
- object_grid_out, out, [7:0][12:0][3:0], registered grid, indexed [y][x], read by the sprite renderer.

Function
REQ-003 Object codes SHALL be: 0 EMPTY, 1 ONION_WHOLE, 2 ONION_CHOPPED, 3 BOWL_EMPTY, 4 BOWL_FULL, 5 POT_EMPTY, 6 POT_RAW, 7 POT_COOKED, 8 POT_FIRE, 9 FIRE, 10 EXTINGUISHER.
REQ-004 FSM states SHALL be IDLE and RESP; cmd_ready_out is 1 only in IDLE.
REQ-005 A command SHALL be accepted on a cycle where cmd_valid_in and cmd_ready_out are both 1.
- On acceptance the FSM moves to RESP.
- The next cycle it returns to IDLE.
- Maximum throughput is one command per 2 cycles.
REQ-006 An accepted in-range command SHALL update the addressed cell on the acceptance edge.
REQ-007 resp_valid_out SHALL be 1 for exactly the RESP cycle.
REQ-008 In RESP, resp_obj_out SHALL show the pre-write cell value for a swap, and 0 for a write.
REQ-009 Out of range (x>12 or y>7):
- The grid is not modified.
- resp_err_out is 1 during RESP.
- resp_obj_out is 0.
REQ-010 resp_err_out and resp_obj_out SHALL be 0 whenever resp_valid_out is 0.
REQ-011 Each pot cell SHALL have its own 16-bit frame counter.
- It increments on frame_tick_in while the cell holds POT_RAW or POT_COOKED.
- It is held at 0 otherwise.
REQ-012 A POT_RAW cell whose counter reaches COOK_FRAMES-1 SHALL, on the next tick, become POT_COOKED, and its counter is cleared.
REQ-013 Any command that writes a pot cell SHALL clear that pot's counter.
REQ-014 A command write and a timer transition in the same cycle on the same cell: the command SHALL win, and the counter is cleared.
REQ-015 Writing EXTINGUISHER to a cell holding POT_FIRE SHALL store POT_EMPTY, not EXTINGUISHER.
REQ-016 Writing EXTINGUISHER to a cell holding FIRE SHALL store EMPTY.
REQ-017 object_grid_out SHALL be driven directly from state registers, with no combinational path from inputs.

Reset
REQ-018 While rst_n_in=0, all of the following SHALL hold, asynchronously:
- Every cell is EMPTY, except the two pot cells, which are POT_EMPTY.
- Counters are 0.
- The FSM is IDLE.
- resp_valid_out, resp_obj_out and resp_err_out are 0.
- cmd_ready_out is 1.
REQ-019 An assertion of reset during RESP SHALL abort the response; no strobe appears after release.

Configuration
REQ-020 The macro GRID_POT_BURN_EN SHALL control pot burning.
- Defined: a POT_COOKED cell whose counter reaches BURN_FRAMES-1 becomes POT_FIRE on the next tick, and its counter is cleared.
- Undefined: POT_COOKED is terminal, and its counter stays 0.

Verification
REQ-021 The bench SHALL cover the following scenarios:
- Reset release -> cells [0][4] and [0][8] = 5, all other cells 0, cmd_ready_out=1.
- Write x=2,y=3,obj=1 -> one cycle later resp_valid_out=1, resp_obj_out=0, grid[3][2]=1, cmd_ready_out=0 for that cycle.
- Swap x=2,y=3,obj=0 after the previous write -> resp_obj_out=1, grid[3][2]=0.
- Write x=13,y=0 -> resp_err_out=1, grid unchanged.
- Write pot0=6, then 180 ticks -> grid[0][4]=7; with GRID_POT_BURN_EN, 240 more ticks -> 8; without it, it stays 7.
- Cell [0][4]=8, write EXTINGUISHER -> 5; a write to pot0 on the same cycle as its cooking transition -> the command value is stored.

Source files
------------

// File: rtl/grid_state_writer.sv
// Object grid store for the kitchen playfield: a command port writes or swaps
// cells, and per-pot frame timers cook pots. Optional macro GRID_POT_BURN_EN enables pot burning.
module grid_state_writer #(
    parameter int unsigned COOK_FRAMES = 180,
    parameter int unsigned BURN_FRAMES = 240,
    parameter int unsigned POT0_X      = 4,
    parameter int unsigned POT0_Y      = 0,
    parameter int unsigned POT1_X      = 8,
    parameter int unsigned POT1_Y      = 0
) (
    input  logic                        pixel_clk_in,
    input  logic                        rst_n_in,
    input  logic                        frame_tick_in,
    input  logic                        cmd_valid_in,
    output logic                        cmd_ready_out,
    input  logic                        cmd_swap_in,
    input  logic [3:0]                  cmd_x_in,
    input  logic [2:0]                  cmd_y_in,
    input  logic [3:0]                  cmd_obj_in,
    output logic                        resp_valid_out,
    output logic [3:0]                  resp_obj_out,
    output logic                        resp_err_out,
    output logic [7:0][12:0][3:0]       object_grid_out
);

    localparam int unsigned GRID_W   = 13;
    localparam int unsigned GRID_H   = 8;
    localparam int unsigned OBJ_W    = 4;
    localparam int unsigned CNT_W    = 16;
    localparam int unsigned NUM_POTS = 2;

    localparam logic [OBJ_W-1:0] OBJ_EMPTY        = 4'd0;
    localparam logic [OBJ_W-1:0] OBJ_POT_EMPTY    = 4'd5;
    localparam logic [OBJ_W-1:0] OBJ_POT_RAW      = 4'd6;
    localparam logic [OBJ_W-1:0] OBJ_POT_COOKED   = 4'd7;
    localparam logic [OBJ_W-1:0] OBJ_POT_FIRE     = 4'd8;
    localparam logic [OBJ_W-1:0] OBJ_FIRE         = 4'd9;
    localparam logic [OBJ_W-1:0] OBJ_EXTINGUISHER = 4'd10;

    typedef logic [GRID_H-1:0][GRID_W-1:0][OBJ_W-1:0] grid_t;
    typedef enum logic {ST_IDLE = 1'b0, ST_RESP = 1'b1} state_e;

    function automatic logic [3:0] pot_x(input int unsigned p);
        return (p == 0) ? 4'(POT0_X) : 4'(POT1_X);
    endfunction

    function automatic logic [2:0] pot_y(input int unsigned p);
        return (p == 0) ? 3'(POT0_Y) : 3'(POT1_Y);
    endfunction

    function automatic grid_t reset_grid();
        grid_t g;
        g = '0;
        g[pot_y(0)][pot_x(0)] = OBJ_POT_EMPTY;
        g[pot_y(1)][pot_x(1)] = OBJ_POT_EMPTY;
        return g;
    endfunction

    state_e                            state_q, state_d;
    logic                              ready_q, ready_d;
    logic                              resp_valid_q, resp_valid_d;
    logic [OBJ_W-1:0]                  resp_obj_q, resp_obj_d;
    logic                              resp_err_q, resp_err_d;
    grid_t                             grid_q, grid_d;
    logic [NUM_POTS-1:0][CNT_W-1:0]    cnt_q, cnt_d;

    logic                              in_range;
    logic [3:0]                        x_idx;
    logic [OBJ_W-1:0]                  old_obj;
    logic [OBJ_W-1:0]                  wr_obj;

    // Row is always in range with a 3-bit field, so only the column is checked.
    always_comb begin
        in_range = (cmd_x_in <= 4'd12);
        x_idx    = in_range ? cmd_x_in : 4'd0;
        old_obj  = grid_q[cmd_y_in][x_idx];
        wr_obj   = cmd_obj_in;
        if (cmd_obj_in == OBJ_EXTINGUISHER && old_obj == OBJ_POT_FIRE) begin
            wr_obj = OBJ_POT_EMPTY;
        end else if (cmd_obj_in == OBJ_EXTINGUISHER && old_obj == OBJ_FIRE) begin
            wr_obj = OBJ_EMPTY;
        end
    end

    // Next state: pot timers first, then an accepted command overrides them.
    always_comb begin
        state_d      = state_q;
        resp_valid_d = 1'b0;
        resp_obj_d   = '0;
        resp_err_d   = 1'b0;
        grid_d       = grid_q;
        cnt_d        = cnt_q;

        for (int unsigned p = 0; p < NUM_POTS; p++) begin
            case (grid_q[pot_y(p)][pot_x(p)])
                OBJ_POT_RAW: begin
                    if (frame_tick_in) begin
                        if (cnt_q[p] == CNT_W'(COOK_FRAMES - 1)) begin
                            grid_d[pot_y(p)][pot_x(p)] = OBJ_POT_COOKED;
                            cnt_d[p] = '0;
                        end else begin
                            cnt_d[p] = cnt_q[p] + CNT_W'(1);
                        end
                    end
                end
                OBJ_POT_COOKED: begin
`ifdef GRID_POT_BURN_EN
                    if (frame_tick_in) begin
                        if (cnt_q[p] == CNT_W'(BURN_FRAMES - 1)) begin
                            grid_d[pot_y(p)][pot_x(p)] = OBJ_POT_FIRE;
                            cnt_d[p] = '0;
                        end else begin
                            cnt_d[p] = cnt_q[p] + CNT_W'(1);
                        end
                    end
`else
                    cnt_d[p] = '0;
`endif
                end
                default: cnt_d[p] = '0;
            endcase
        end

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid_in) begin
                    state_d      = ST_RESP;
                    resp_valid_d = 1'b1;
                    resp_err_d   = !in_range;
                    if (in_range) begin
                        grid_d[cmd_y_in][x_idx] = wr_obj;
                        if (cmd_swap_in) begin
                            resp_obj_d = old_obj;
                        end
                        for (int unsigned p = 0; p < NUM_POTS; p++) begin
                            if (cmd_x_in == pot_x(p) && cmd_y_in == pot_y(p)) begin
                                cnt_d[p] = '0;
                            end
                        end
                    end
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q      <= ST_IDLE;
            ready_q      <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_obj_q   <= '0;
            resp_err_q   <= 1'b0;
            grid_q       <= reset_grid();
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            ready_q      <= ready_d;
            resp_valid_q <= resp_valid_d;
            resp_obj_q   <= resp_obj_d;
            resp_err_q   <= resp_err_d;
            grid_q       <= grid_d;
            cnt_q        <= cnt_d;
        end
    end

    assign cmd_ready_out   = ready_q;
    assign resp_valid_out  = resp_valid_q;
    assign resp_obj_out    = resp_obj_q;
    assign resp_err_out    = resp_err_q;
    assign object_grid_out = grid_q;

endmodule
